// File: rtl/tdm_demux_if.sv
// tdm_demux_if: serial TDM input and demultiplexed output bundle for tdm_demux_1_8
interface tdm_demux_if #(parameter int SEL_W = 3);
  localparam int N = 2**SEL_W;
  logic din, valid, sync;
  logic [N-1:0] y, frame;
  logic frame_valid, locked, sync_err;
  logic [SEL_W-1:0] slot;
  modport master(output din, valid, sync, input y, frame, frame_valid, slot, locked, sync_err);
  modport slave(input din, valid, sync, output y, frame, frame_valid, slot, locked, sync_err);
endinterface

// File: rtl/tdm_demux_1_8.sv
// tdm_demux_1_8: serial TDM receiver routing bits to 2**SEL_W channels with frame-sync tracking
module tdm_demux_1_8 #(parameter int SEL_W = 3) (
  input logic clk,
  input logic rst_n,
  tdm_demux_if.slave bus
);
  localparam int N = 2**SEL_W;
  typedef enum logic {HUNT, LOCKED} state_t;
  state_t state;
  logic [N-1:0] shadow, next_shadow;
  logic [SEL_W-1:0] idx;
  logic acc, miss, early;
  always_comb begin
    idx = bus.sync ? '0 : bus.slot;
    acc = bus.valid && (bus.sync || (state == LOCKED && bus.slot != '0));
    miss = bus.valid && state == LOCKED && !bus.sync && bus.slot == '0;
    early = bus.valid && state == LOCKED && bus.sync && bus.slot != '0;
    next_shadow = bus.sync ? '0 : shadow;
    next_shadow[idx] = bus.din;
  end
  // a sync bit always starts a fresh shadow frame, which also abandons any partial one
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= HUNT;
      shadow <= '0;
      bus.y <= '0;
      bus.frame <= '0;
      bus.frame_valid <= 1'b0;
      bus.slot <= '0;
      bus.locked <= 1'b0;
      bus.sync_err <= 1'b0;
    end else begin
      bus.frame_valid <= acc && &idx;
      bus.sync_err <= miss || early;
      if (acc) begin
        state <= LOCKED;
        bus.locked <= 1'b1;
        shadow <= next_shadow;
        bus.y[idx] <= bus.din;
        bus.slot <= idx + 1'b1;
        if (&idx) bus.frame <= next_shadow;
      end else if (miss) begin
        state <= HUNT;
        bus.locked <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_tdm_demux_1_8.sv
// tb_tdm_demux_1_8: directed test-plan scenarios plus random traffic against a queue-based frame model
module tb_tdm_demux_1_8;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_checks = 0;
  int n_fail = 0;
  tdm_demux_if #(.SEL_W(3)) bus();
  tdm_demux_1_8 #(.SEL_W(3)) dut(.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;

  bit m_locked;
  bit q[$];
  logic [7:0] m_y, m_frame;
  bit m_fv, m_err;

  task automatic cyc(input bit v, input bit s, input bit d);
    bus.valid = v;
    bus.sync = s;
    bus.din = d;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s got %0h want %0h", name, got, want);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    cyc(1, 1, 1);
    cyc(1, 0, 1);
    n_checks++;
    if (bus.y !== 8'h00) begin n_fail++; $display("FAIL reset_y got %h want 00", bus.y); end
    n_checks++;
    if (bus.frame !== 8'h00) begin n_fail++; $display("FAIL reset_frame got %h want 00", bus.frame); end
    n_checks++;
    if (bus.slot !== 3'd0) begin n_fail++; $display("FAIL reset_slot got %0d want 0", bus.slot); end
    n_checks++;
    if ({bus.locked, bus.frame_valid, bus.sync_err} !== 3'b000) begin
      n_fail++; $display("FAIL reset_flags got %b want 000", {bus.locked, bus.frame_valid, bus.sync_err});
    end
    rst_n = 1'b1;
  endtask

  task automatic test_lock;
    logic [7:0] f = 8'hA5;
    cyc(0, 0, 0);
    cyc(1, 1, f[0]);
    n_checks++;
    if (bus.locked !== 1'b1) begin n_fail++; $display("FAIL lock_locked got %b want 1", bus.locked); end
    n_checks++;
    if (bus.slot !== 3'd1) begin n_fail++; $display("FAIL lock_slot1 got %0d want 1", bus.slot); end
    for (int k = 1; k < 8; k++) begin
      cyc(1, 0, f[k]);
      if (k < 7) begin
        n_checks++;
        if (bus.frame_valid !== 1'b0) begin n_fail++; $display("FAIL lock_early_fv got %b want 0", bus.frame_valid); end
      end
    end
    n_checks++;
    if (bus.frame !== 8'hA5) begin n_fail++; $display("FAIL lock_frame got %h want a5", bus.frame); end
    n_checks++;
    if (bus.frame_valid !== 1'b1) begin n_fail++; $display("FAIL lock_fv got %b want 1", bus.frame_valid); end
    n_checks++;
    if (bus.y !== 8'hA5) begin n_fail++; $display("FAIL lock_y got %h want a5", bus.y); end
    n_checks++;
    if (bus.slot !== 3'd0) begin n_fail++; $display("FAIL lock_slot0 got %0d want 0", bus.slot); end
    cyc(0, 0, 0);
    n_checks++;
    if (bus.frame_valid !== 1'b0) begin n_fail++; $display("FAIL lock_fv_pulse got %b want 0", bus.frame_valid); end
  endtask

  task automatic test_continuous;
    logic [15:0] bits = 16'hFF3C;
    int fv1 = -1, fv2 = -1, errs = 0;
    logic [7:0] cap1 = 8'h00, cap2 = 8'h00;
    for (int k = 0; k < 16; k++) begin
      cyc(1, (k % 8) == 0, bits[k]);
      if (bus.sync_err) errs++;
      if (bus.frame_valid) begin
        if (fv1 < 0) begin fv1 = k; cap1 = bus.frame; end
        else begin fv2 = k; cap2 = bus.frame; end
      end
    end
    n_checks++;
    if (fv1 != 7) begin n_fail++; $display("FAIL cont_fv1 got %0d want 7", fv1); end
    n_checks++;
    if (fv2 != 15) begin n_fail++; $display("FAIL cont_fv2 got %0d want 15", fv2); end
    n_checks++;
    if (cap1 !== 8'h3C) begin n_fail++; $display("FAIL cont_frame1 got %h want 3c", cap1); end
    n_checks++;
    if (cap2 !== 8'hFF) begin n_fail++; $display("FAIL cont_frame2 got %h want ff", cap2); end
    n_checks++;
    if (errs != 0) begin n_fail++; $display("FAIL cont_sync_err got %0d want 0", errs); end
  endtask

  task automatic test_gapped;
    logic [7:0] f = 8'h81;
    for (int k = 0; k < 4; k++) cyc(1, k == 0, f[k]);
    for (int g = 0; g < 3; g++) begin
      cyc(0, 1, 1);
      n_checks++;
      if (bus.slot !== 3'd4) begin n_fail++; $display("FAIL gap_slot got %0d want 4", bus.slot); end
      n_checks++;
      if (bus.frame_valid !== 1'b0 || bus.sync_err !== 1'b0) begin
        n_fail++; $display("FAIL gap_pulse got %b%b want 00", bus.frame_valid, bus.sync_err);
      end
    end
    for (int k = 4; k < 8; k++) cyc(1, 0, f[k]);
    n_checks++;
    if (bus.frame !== 8'h81) begin n_fail++; $display("FAIL gap_frame got %h want 81", bus.frame); end
    n_checks++;
    if (bus.frame_valid !== 1'b1) begin n_fail++; $display("FAIL gap_fv got %b want 1", bus.frame_valid); end
  endtask

  task automatic test_missing_sync;
    logic [7:0] y0;
    y0 = bus.y;
    cyc(1, 0, ~y0[0]);
    n_checks++;
    if (bus.sync_err !== 1'b1) begin n_fail++; $display("FAIL miss_err got %b want 1", bus.sync_err); end
    n_checks++;
    if (bus.locked !== 1'b0) begin n_fail++; $display("FAIL miss_locked got %b want 0", bus.locked); end
    n_checks++;
    if (bus.slot !== 3'd0) begin n_fail++; $display("FAIL miss_slot got %0d want 0", bus.slot); end
    n_checks++;
    if (bus.frame !== 8'h81) begin n_fail++; $display("FAIL miss_frame got %h want 81", bus.frame); end
    n_checks++;
    if (bus.y !== y0) begin n_fail++; $display("FAIL miss_y got %h want %h", bus.y, y0); end
    cyc(1, 0, 1);
    n_checks++;
    if (bus.sync_err !== 1'b0 || bus.slot !== 3'd0) begin
      n_fail++; $display("FAIL miss_hunt got err=%b slot=%0d want err=0 slot=0", bus.sync_err, bus.slot);
    end
    cyc(1, 1, 0);
    n_checks++;
    if (bus.locked !== 1'b1 || bus.slot !== 3'd1) begin
      n_fail++; $display("FAIL miss_relock got locked=%b slot=%0d want locked=1 slot=1", bus.locked, bus.slot);
    end
  endtask

  task automatic test_early_sync;
    logic [7:0] f = 8'h5A;
    int fvs = 0;
    for (int k = 1; k < 5; k++) cyc(1, 0, 1);
    n_checks++;
    if (bus.slot !== 3'd5) begin n_fail++; $display("FAIL early_pre_slot got %0d want 5", bus.slot); end
    cyc(1, 1, f[0]);
    n_checks++;
    if (bus.sync_err !== 1'b1) begin n_fail++; $display("FAIL early_err got %b want 1", bus.sync_err); end
    n_checks++;
    if (bus.slot !== 3'd1 || bus.locked !== 1'b1) begin
      n_fail++; $display("FAIL early_realign got slot=%0d locked=%b want slot=1 locked=1", bus.slot, bus.locked);
    end
    for (int k = 1; k < 8; k++) begin
      cyc(1, 0, f[k]);
      if (bus.frame_valid) fvs++;
    end
    n_checks++;
    if (fvs != 1) begin n_fail++; $display("FAIL early_fv_count got %0d want 1", fvs); end
    n_checks++;
    if (bus.frame !== 8'h5A) begin n_fail++; $display("FAIL early_frame got %h want 5a", bus.frame); end
  endtask

  task automatic test_reset_mid;
    int fvs = 0;
    for (int k = 0; k < 3; k++) cyc(1, k == 0, 1);
    n_checks++;
    if (bus.slot !== 3'd3) begin n_fail++; $display("FAIL rmid_pre_slot got %0d want 3", bus.slot); end
    rst_n = 1'b0;
    cyc(1, 1, 1);
    rst_n = 1'b1;
    n_checks++;
    if ({bus.y, bus.frame, bus.slot, bus.locked, bus.frame_valid, bus.sync_err} !== 22'd0) begin
      n_fail++; $display("FAIL rmid_zero got y=%h frame=%h slot=%0d flags=%b%b%b want all 0",
        bus.y, bus.frame, bus.slot, bus.locked, bus.frame_valid, bus.sync_err);
    end
    for (int k = 0; k < 8; k++) begin
      cyc(1, 0, 1);
      if (bus.frame_valid || bus.sync_err || bus.slot != 3'd0) fvs++;
    end
    n_checks++;
    if (fvs != 0) begin n_fail++; $display("FAIL rmid_nosync got %0d events want 0", fvs); end
    n_checks++;
    if (bus.y !== 8'h00 || bus.locked !== 1'b0) begin
      n_fail++; $display("FAIL rmid_hunt got y=%h locked=%b want y=00 locked=0", bus.y, bus.locked);
    end
  endtask

  task automatic test_random;
    bit v, s, d;
    rst_n = 1'b0;
    cyc(0, 0, 0);
    rst_n = 1'b1;
    m_locked = 0; q.delete(); m_y = 8'h00; m_frame = 8'h00;
    for (int c = 0; c < 600; c++) begin
      v = ($urandom % 4) != 0;
      s = (q.size() == 0) ? (($urandom % 6) != 0) : (($urandom % 12) == 0);
      d = $urandom % 2;
      cyc(v, s, d);
      m_fv = 0; m_err = 0;
      if (v) begin
        if (s) begin
          if (m_locked && q.size() != 0) m_err = 1;
          q.delete();
          q.push_back(d);
          m_y[0] = d;
          m_locked = 1;
        end else if (m_locked) begin
          if (q.size() == 0) begin m_err = 1; m_locked = 0; end
          else begin m_y[q.size()] = d; q.push_back(d); end
        end
        if (q.size() == 8) begin
          for (int k = 0; k < 8; k++) m_frame[k] = q[k];
          m_fv = 1;
          q.delete();
        end
      end
      chk("rnd_y", 32'(bus.y), 32'(m_y));
      chk("rnd_frame", 32'(bus.frame), 32'(m_frame));
      chk("rnd_fv", 32'(bus.frame_valid), 32'(m_fv));
      chk("rnd_err", 32'(bus.sync_err), 32'(m_err));
      chk("rnd_slot", 32'(bus.slot), 32'(q.size()));
      chk("rnd_locked", 32'(bus.locked), 32'(m_locked));
    end
  endtask

  initial begin
    bus.valid = 1'b0;
    bus.sync = 1'b0;
    bus.din = 1'b0;
    test_reset();
    test_lock();
    test_continuous();
    test_gapped();
    test_missing_sync();
    test_early_sync();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
